// File: rtl/pll_reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer_if
//
// Groups the PLL-facing and domain-facing signals of the PLL reset
// sequencer so they can be passed around as one bundle.
//
// Signals:
//   pll_locked     PLL lock flag (asynchronous to inclk0)
//   force_restart  single-cycle request to restart the bring-up sequence
//   pll_areset     reset to the PLL, active high
//   rst_c0         active-high reset for the c0 (50 MHz system) domain
//   rst_c1         active-high reset for the c1 (25 MHz VGA) domain
//   ready          both domains released and the PLL is locked
//   fault          lock attempts exhausted; sequence parked
//   retry_count    timed-out lock attempts since rst/force_restart (sat. 3)
//
// Modports:
//   master  the sequencer: consumes lock/restart, drives resets and status
//   slave   the PLL/system side: drives lock/restart, observes the rest
// ---------------------------------------------------------------------------
interface pll_reset_sequencer_if;
   logic       pll_locked;
   logic       force_restart;
   logic       pll_areset;
   logic       rst_c0;
   logic       rst_c1;
   logic       ready;
   logic       fault;
   logic [1:0] retry_count;

   modport master (
      input  pll_locked,
      input  force_restart,
      output pll_areset,
      output rst_c0,
      output rst_c1,
      output ready,
      output fault,
      output retry_count
   );

   modport slave (
      output pll_locked,
      output force_restart,
      input  pll_areset,
      input  rst_c0,
      input  rst_c1,
      input  ready,
      input  fault,
      input  retry_count
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Startup and recovery controller for the system PLL (c0 = 50 MHz system,
// c1 = 25 MHz VGA). Pulses the PLL reset, waits for a qualified lock, then
// releases the c0 domain followed by the c1 domain. Loss of lock pulls both
// domains back into reset and restarts the PLL; a lock timeout retries the
// PLL reset, and after MAX_RETRIES timed-out retries a further timeout
// parks the sequencer in a fault state until rst or force_restart.
//
// Ports:
//   inclk0  free-running board clock; the only clock
//   rst     synchronous, active-high reset
//   bus     pll_reset_sequencer_if.master (lock/restart in, resets/status out)
//
// Parameters:
//   RESET_CYCLES         width of the pll_areset pulse
//   LOCK_STABLE_CYCLES   qualified-lock time before the c0 release
//   LOCK_TIMEOUT_CYCLES  cycles spent waiting for lock per attempt
//   DOMAIN_GAP_CYCLES    delay from rst_c0 release to rst_c1 release
//   MAX_RETRIES          timed-out attempts tolerated before fault (0..3)
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int RESET_CYCLES        = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int DOMAIN_GAP_CYCLES   = 8,
   parameter int MAX_RETRIES         = 3
) (
   input logic                   inclk0,
   input logic                   rst,
   pll_reset_sequencer_if.master bus
);

   // One shared counter, wide enough for the longest interval.
   localparam int MAX_AB     = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
   localparam int MAX_CD     = (LOCK_TIMEOUT_CYCLES > DOMAIN_GAP_CYCLES) ? LOCK_TIMEOUT_CYCLES : DOMAIN_GAP_CYCLES;
   localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   // The counter starts at 0 on state entry, so an interval of N cycles
   // ends on the cycle where it reads N-1.
   localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(DOMAIN_GAP_CYCLES - 1);

   // retry_count is only 2 bits wide, so the limit is clamped to 3.
   localparam logic [1:0] RETRY_LIMIT = 2'((MAX_RETRIES > 3) ? 3 : MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_REL_C0,
      ST_RUN,
      ST_FAULT
   } state_t;

   typedef struct packed {
      logic pll_areset;
      logic rst_c0;
      logic rst_c1;
      logic ready;
      logic fault;
   } outs_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [1:0]       retry_next;
   outs_t            outs_next;
   logic             sync_meta;
   logic             locked_s;

   // -------------------------------------------------------------------------
   // pll_locked synchroniser. Cleared by rst so a fresh sequence never acts
   // on a lock sample taken before the reset.
   // -------------------------------------------------------------------------
   // NOTE: clocked blocks use non-blocking assignments only, so every flop
   // samples the pre-edge value of its source regardless of statement order.
   always_ff @(posedge inclk0) begin
      if (rst) begin
         sync_meta <= 1'b0;
         locked_s  <= 1'b0;
      end else begin
         sync_meta <= bus.pll_locked;
         locked_s  <= sync_meta;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state, retry and counter logic.
   // Priority: force_restart > loss of lock > counter/timeout transitions
   // (rst is handled in the register process and beats all of them).
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      retry_next = bus.retry_count;
      cnt_next   = cnt;

      if (bus.force_restart) begin
         state_next = ST_PLL_RST;
         retry_next = 2'd0;
      end else if (!locked_s && (state == ST_REL_C0 || state == ST_RUN)) begin
         // Domains go back into reset together; no partial release.
         state_next = ST_PLL_RST;
      end else begin
         unique case (state)
            ST_PLL_RST: begin
               if (cnt == RESET_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state_next = ST_STABLE;
               end else if (cnt == TIMEOUT_LAST) begin
                  if (bus.retry_count == RETRY_LIMIT) begin
                     state_next = ST_FAULT;
                  end else begin
                     state_next = ST_PLL_RST;
                     if (bus.retry_count != 2'd3) retry_next = bus.retry_count + 2'd1;
                  end
               end
            end
            ST_STABLE: begin
               // Any dropout restarts the wait with a fresh timeout.
               if (!locked_s)                state_next = ST_WAIT_LOCK;
               else if (cnt == STABLE_LAST)  state_next = ST_REL_C0;
            end
            ST_REL_C0: begin
               if (cnt == GAP_LAST) state_next = ST_RUN;
            end
            ST_RUN:   state_next = ST_RUN;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_PLL_RST;
         endcase
      end

      // Counter clears on every state entry (force_restart re-enters
      // PLL_RST even from PLL_RST) and idles in the terminal states.
      if (bus.force_restart || state_next != state) begin
         cnt_next = '0;
      end else if (state == ST_RUN || state == ST_FAULT) begin
         cnt_next = cnt;
      end else begin
         cnt_next = cnt + 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Output decode from the next state, so the registered outputs line up
   // with the state they describe.
   // -------------------------------------------------------------------------
   always_comb begin
      outs_next = '{pll_areset: 1'b1, rst_c0: 1'b1, rst_c1: 1'b1, ready: 1'b0, fault: 1'b0};
      case (state_next)
         ST_WAIT_LOCK, ST_STABLE: begin
            outs_next.pll_areset = 1'b0;
         end
         ST_REL_C0: begin
            outs_next.pll_areset = 1'b0;
            outs_next.rst_c0     = 1'b0;
         end
         ST_RUN: begin
            outs_next.pll_areset = 1'b0;
            outs_next.rst_c0     = 1'b0;
            outs_next.rst_c1     = 1'b0;
            outs_next.ready      = 1'b1;
         end
         ST_FAULT: begin
            outs_next.fault = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State, counter and registered outputs.
   // -------------------------------------------------------------------------
   always_ff @(posedge inclk0) begin
      if (rst) begin
         state           <= ST_PLL_RST;
         cnt             <= '0;
         bus.retry_count <= 2'd0;
         bus.pll_areset  <= 1'b1;
         bus.rst_c0      <= 1'b1;
         bus.rst_c1      <= 1'b1;
         bus.ready       <= 1'b0;
         bus.fault       <= 1'b0;
      end else begin
         state           <= state_next;
         cnt             <= cnt_next;
         bus.retry_count <= retry_next;
         bus.pll_areset  <= outs_next.pll_areset;
         bus.rst_c0      <= outs_next.rst_c0;
         bus.rst_c1      <= outs_next.rst_c1;
         bus.ready       <= outs_next.ready;
         bus.fault       <= outs_next.fault;
      end
   end

endmodule
